// File: rtl/div_unit.sv
// div_unit: restoring radix-2 divider for a HI/LO register file.
// Takes one iteration per clock; supports signed and unsigned operands, annul, and a divide-by-zero fast path.
`default_nettype none

module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic              annul_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic              we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [2*DATA_W:0]   rem;
  logic [DATA_W-1:0]   divisor;
  logic                neg_q;
  logic                neg_r;

  logic [2*DATA_W:0]   rem_next;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   q_res;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;

  // rem holds {partial remainder (DATA_W+1 bits), dividend/quotient (DATA_W bits)}
  always_comb begin
    rem_next = rem << 1;
    if (rem_next[2*DATA_W:DATA_W] >= {1'b0, divisor}) begin
      rem_next[2*DATA_W:DATA_W] = rem_next[2*DATA_W:DATA_W] - {1'b0, divisor};
      rem_next[0]               = 1'b1;
    end
    q_mag = rem_next[DATA_W-1:0];
    r_mag = rem_next[2*DATA_W-1:DATA_W];
    q_res = neg_q ? (~q_mag + 1'b1) : q_mag;
    r_res = neg_r ? (~r_mag + 1'b1) : r_mag;
  end

  // The most negative dividend has no positive counterpart; its magnitude wraps to the same unsigned value.
  always_comb begin
    a_mag = (signed_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    b_mag = (signed_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      busy_o  <= 1'b0;
      ready_o <= 1'b0;
      we_o    <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      ready_o <= 1'b0;
      we_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            rem     <= {{(DATA_W+1){1'b0}}, a_mag};
            divisor <= b_mag;
            neg_q   <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r   <= signed_i & opdata1_i[DATA_W-1];
            count   <= '0;
            busy_o  <= 1'b1;
            state   <= (opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state   <= END;
            ready_o <= 1'b1;
            we_o    <= 1'b1;
            hi_o    <= '0;
            lo_o    <= '0;
          end
        end
        ON: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            count  <= '0;
          end else begin
            rem <= rem_next;
            if (count == LAST_CNT) begin
              state   <= END;
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
              we_o    <= 1'b1;
              hi_o    <= r_res;
              lo_o    <= q_res;
              count   <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        END: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
